// File: rtl/axis_stream_checker.sv
// -----------------------------------------------------------------------------
// axis_stream_checker
//
// Sink-side checker for a 64-bit AXI-Stream-like interface. It throttles the
// stream with pseudo-random backpressure and checks every accepted beat:
//   * data  : each enabled byte lane k must carry (off + k) mod 256, where off
//             is the byte offset of the beat inside its packet,
//   * keep  : non-LAST beats carry 8'hFF; the LAST beat carries a nonzero,
//             LSB-contiguous mask,
//   * length: a packet may not reach MAX_BEATS beats without LAST. The rest
//             of such a packet is drained up to its LAST without checking.
// At most one error is counted per beat, priority length > keep > data.
//
// Parameters
//   SEED      : reset value of the backpressure LFSR (0 is replaced by 16'hACE1)
//   BP_ENABLE : 1 = pseudo-random READY, 0 = READY permanently high
//   MAX_BEATS : maximum legal beats per packet
//
// Ports
//   clk             : clock, everything is clocked on its rising edge
//   resetn          : synchronous active-low reset
//   stream_in_DATA  : 64-bit payload
//   stream_in_KEEP  : byte enables, bit k qualifies DATA[8k+7:8k]
//   stream_in_LAST  : final beat of a packet
//   stream_in_VALID : beat valid
//   stream_in_READY : checker accepts the beat (registered)
//   pkt_count       : completed packets (wraps at 2^32)
//   byte_count      : accepted bytes, popcount of KEEP (wraps at 2^32)
//   err_count       : detected errors, saturating
//   err_flag        : sticky, any error since reset
//   first_err_code  : type of the first error (01 data, 10 keep, 11 length)
// -----------------------------------------------------------------------------
module axis_stream_checker #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          BP_ENABLE = 1,
  parameter int          MAX_BEATS = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [63:0] stream_in_DATA,
  input  logic [7:0]  stream_in_KEEP,
  input  logic        stream_in_LAST,
  input  logic        stream_in_VALID,
  output logic        stream_in_READY,
  output logic [31:0] pkt_count,
  output logic [31:0] byte_count,
  output logic [15:0] err_count,
  output logic        err_flag,
  output logic [1:0]  first_err_code
);

  // An all-zero LFSR would lock up, so a zero seed falls back to the default.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  // Beat counter wide enough to hold MAX_BEATS itself.
  localparam int                CNT_W        = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0]  MAX_BEAT_NUM = CNT_W'(MAX_BEATS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,   // no packet open
    S_IN_PKT = 2'd1,   // packet open, beats are checked
    S_DRAIN  = 2'd2    // discarding the remainder after a length error
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_DATA = 2'b01,
    ERR_KEEP = 2'b10,
    ERR_LEN  = 2'b11
  } err_code_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q;
  logic [15:0]      lfsr_q;
  logic             ready_q;
  logic [CNT_W-1:0] beat_cnt_q;     // beats already accepted in the open packet
  logic [7:0]       off_q;          // byte offset of the next beat, mod 256
  logic [31:0]      pkt_cnt_q;
  logic [31:0]      byte_cnt_q;
  logic [15:0]      err_cnt_q;
  logic             err_flag_q;
  err_code_t        first_code_q;

  // ---------------------------------------------------------------------------
  // Next-value helpers
  // ---------------------------------------------------------------------------
  logic             accept;
  logic             lfsr_fb;
  logic [15:0]      lfsr_d;
  logic             ready_d;
  logic [CNT_W-1:0] beat_num_d;     // 1-based number of the current beat
  logic [3:0]       keep_bytes;
  logic [8:0]       keep_plus1;
  logic             keep_contig;
  logic             keep_ok;
  logic             data_ok;
  logic             len_hit;
  err_code_t        beat_err;

  // NOTE: every signal driven from always_comb gets a default at the top of
  // the block, so no path through it can leave a value held (latch).
  always_comb begin
    accept = stream_in_VALID & ready_q;

    // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
    lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d  = {lfsr_fb, lfsr_q[15:1]};

    // READY is the registered image of the LFSR's two low bits (~75% high).
    ready_d = (BP_ENABLE != 0) ? (lfsr_q[0] | lfsr_q[1]) : 1'b1;

    beat_num_d = beat_cnt_q + CNT_W'(1);
  end

  // Byte count of the beat and KEEP legality.
  always_comb begin
    keep_bytes = 4'd0;
    for (int k = 0; k < 8; k++) begin
      keep_bytes = keep_bytes + {3'b000, stream_in_KEEP[k]};
    end

    // A mask of the form 0..01..1 becomes a power of two when incremented,
    // so it shares no set bit with its successor.
    keep_plus1  = {1'b0, stream_in_KEEP} + 9'd1;
    keep_contig = (stream_in_KEEP != 8'h00) &&
                  (({1'b0, stream_in_KEEP} & keep_plus1) == 9'd0);
    keep_ok     = stream_in_LAST ? keep_contig : (stream_in_KEEP == 8'hFF);
  end

  // Payload check: only enabled lanes are compared.
  always_comb begin
    data_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (stream_in_KEEP[k] && (stream_in_DATA[8*k +: 8] != (off_q + 8'(k)))) begin
        data_ok = 1'b0;
      end
    end
  end

  // One error per beat at most; length outranks keep, keep outranks data.
  always_comb begin
    len_hit  = !stream_in_LAST && (beat_num_d == MAX_BEAT_NUM);
    beat_err = ERR_NONE;
    if (state_q != S_DRAIN) begin
      if (len_hit) begin
        beat_err = ERR_LEN;
      end else if (!keep_ok) begin
        beat_err = ERR_KEEP;
      end else if (!data_ok) begin
        beat_err = ERR_DATA;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state: LFSR, READY, packet FSM and statistics
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= only, so every register samples
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      lfsr_q       <= SEED_EFF;
      ready_q      <= 1'b0;
      beat_cnt_q   <= '0;
      off_q        <= 8'd0;
      pkt_cnt_q    <= 32'd0;
      byte_cnt_q   <= 32'd0;
      err_cnt_q    <= 16'd0;
      err_flag_q   <= 1'b0;
      first_code_q <= ERR_NONE;
    end else begin
      // The LFSR and READY run every cycle, independent of the handshake.
      lfsr_q  <= lfsr_d;
      ready_q <= ready_d;

      if (accept) begin
        byte_cnt_q <= byte_cnt_q + 32'(keep_bytes);

        if (stream_in_LAST) begin
          pkt_cnt_q <= pkt_cnt_q + 32'd1;
        end

        if (beat_err != ERR_NONE) begin
          if (err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
          end
          // Only the first error type is kept.
          if (!err_flag_q) begin
            err_flag_q   <= 1'b1;
            first_code_q <= beat_err;
          end
        end

        case (state_q)
          S_IDLE, S_IN_PKT: begin
            if (beat_err == ERR_LEN) begin
              state_q    <= S_DRAIN;
              beat_cnt_q <= '0;
              off_q      <= 8'd0;
            end else if (stream_in_LAST) begin
              state_q    <= S_IDLE;
              beat_cnt_q <= '0;
              off_q      <= 8'd0;
            end else begin
              state_q    <= S_IN_PKT;
              beat_cnt_q <= beat_num_d;
              off_q      <= off_q + 8'd8;
            end
          end
          S_DRAIN: begin
            if (stream_in_LAST) begin
              state_q <= S_IDLE;
            end
          end
          default: begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            off_q      <= 8'd0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from registers.
  // ---------------------------------------------------------------------------
  assign stream_in_READY = ready_q;
  assign pkt_count       = pkt_cnt_q;
  assign byte_count      = byte_cnt_q;
  assign err_count       = err_cnt_q;
  assign err_flag        = err_flag_q;
  assign first_err_code  = first_code_q;

endmodule

// File: tb/tb_axis_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_axis_stream_checker
//
// Two checker instances share clock and reset:
//   u_dut0 : BP_ENABLE=0, MAX_BEATS=4  (permanent READY, short length limit)
//   u_dut1 : BP_ENABLE=1, SEED=0       (pseudo-random READY, default limit)
// A behavioural model of each instance advances on every rising edge and the
// outputs are compared against it on every falling edge. Directed scenarios
// add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_axis_stream_checker;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // Stimulus, one set per instance.
  logic [63:0] d0_data  = 64'h0;
  logic [7:0]  d0_keep  = 8'h0;
  logic        d0_last  = 1'b0;
  logic        d0_valid = 1'b0;
  logic [63:0] d1_data  = 64'h0;
  logic [7:0]  d1_keep  = 8'h0;
  logic        d1_last  = 1'b0;
  logic        d1_valid = 1'b0;

  // Observed outputs.
  logic        rdy0, rdy1;
  logic [31:0] pkt0, pkt1, byt0, byt1;
  logic [15:0] err0, err1;
  logic        flag0, flag1;
  logic [1:0]  code0, code1;

  int n_cmp  = 0;
  int n_fail = 0;

  axis_stream_checker #(.SEED(16'hACE1), .BP_ENABLE(0), .MAX_BEATS(4)) u_dut0 (
    .clk             (clk),
    .resetn          (resetn),
    .stream_in_DATA  (d0_data),
    .stream_in_KEEP  (d0_keep),
    .stream_in_LAST  (d0_last),
    .stream_in_VALID (d0_valid),
    .stream_in_READY (rdy0),
    .pkt_count       (pkt0),
    .byte_count      (byt0),
    .err_count       (err0),
    .err_flag        (flag0),
    .first_err_code  (code0)
  );

  axis_stream_checker #(.SEED(16'h0000), .BP_ENABLE(1), .MAX_BEATS(256)) u_dut1 (
    .clk             (clk),
    .resetn          (resetn),
    .stream_in_DATA  (d1_data),
    .stream_in_KEEP  (d1_keep),
    .stream_in_LAST  (d1_last),
    .stream_in_VALID (d1_valid),
    .stream_in_READY (rdy1),
    .pkt_count       (pkt1),
    .byte_count      (byt1),
    .err_count       (err1),
    .err_flag        (flag1),
    .first_err_code  (code1)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model: packet state kept as "beats seen" plus a drain flag;
  // offset is derived from the beat number.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] lfsr;
    bit          ready;
    bit          draining;
    int          beats;
    logic [31:0] pkts;
    logic [31:0] bytes;
    int          errs;
    bit          flag;
    logic [1:0]  code;
  } model_t;

  model_t m0, m1;
  bit     mdl_live = 1'b0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    int v;
    int b;
    v = int'(l);
    b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return 16'((v >> 1) | (b << 15));
  endfunction

  function automatic bit keep_legal(input logic [7:0] keep, input bit last);
    if (!last) return keep == 8'hFF;
    for (int n = 1; n <= 8; n++) begin
      if (int'(keep) == (1 << n) - 1) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit data_legal(input logic [63:0] data, input logic [7:0] keep, input int off);
    for (int k = 0; k < 8; k++) begin
      if (keep[k] && (int'(data[8*k +: 8]) != ((off + k) % 256))) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic model_t model_step(input model_t s, input bit rst_n, input bit valid,
                                        input logic [63:0] data, input logic [7:0] keep,
                                        input bit last, input bit bp_en, input int max_beats,
                                        input logic [15:0] seed);
    model_t     n;
    logic [1:0] err;
    int         nb;
    n = s;
    if (!rst_n) begin
      n.lfsr     = (seed == 16'h0000) ? 16'hACE1 : seed;
      n.ready    = 1'b0;
      n.draining = 1'b0;
      n.beats    = 0;
      n.pkts     = 32'd0;
      n.bytes    = 32'd0;
      n.errs     = 0;
      n.flag     = 1'b0;
      n.code     = 2'b00;
      return n;
    end
    n.ready = bp_en ? (s.lfsr[0] | s.lfsr[1]) : 1'b1;
    n.lfsr  = lfsr_step(s.lfsr);
    if (!(valid && s.ready)) return n;

    nb = 0;
    for (int k = 0; k < 8; k++) if (keep[k]) nb++;
    n.bytes = s.bytes + 32'(nb);

    if (s.draining) begin
      if (last) begin
        n.draining = 1'b0;
        n.pkts     = s.pkts + 32'd1;
      end
      return n;
    end

    err = 2'b00;
    if (!last && (s.beats + 1 == max_beats))           err = 2'b11;
    else if (!keep_legal(keep, last))                  err = 2'b10;
    else if (!data_legal(data, keep, (s.beats * 8) % 256)) err = 2'b01;

    if (err != 2'b00) begin
      if (s.errs < 65535) n.errs = s.errs + 1;
      if (!s.flag) begin
        n.flag = 1'b1;
        n.code = err;
      end
    end

    if (err == 2'b11) begin
      n.draining = 1'b1;
      n.beats    = 0;
    end else if (last) begin
      n.beats = 0;
      n.pkts  = s.pkts + 32'd1;
    end else begin
      n.beats = s.beats + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m0 = model_step(m0, resetn, d0_valid, d0_data, d0_keep, d0_last, 1'b0, 4, 16'hACE1);
    m1 = model_step(m1, resetn, d1_valid, d1_data, d1_keep, d1_last, 1'b1, 256, 16'h0000);
    if (!resetn) mdl_live = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mdl_live) begin
      check("m.d0.ready", 64'(rdy0),  64'(m0.ready));
      check("m.d0.pkts",  64'(pkt0),  64'(m0.pkts));
      check("m.d0.bytes", 64'(byt0),  64'(m0.bytes));
      check("m.d0.errs",  64'(err0),  64'(m0.errs));
      check("m.d0.flag",  64'(flag0), 64'(m0.flag));
      check("m.d0.code",  64'(code0), 64'(m0.code));
      check("m.d1.ready", 64'(rdy1),  64'(m1.ready));
      check("m.d1.pkts",  64'(pkt1),  64'(m1.pkts));
      check("m.d1.bytes", 64'(byt1),  64'(m1.bytes));
      check("m.d1.errs",  64'(err1),  64'(m1.errs));
      check("m.d1.flag",  64'(flag1), 64'(m1.flag));
      check("m.d1.code",  64'(code1), 64'(m1.code));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called at a falling edge)
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] pat(input int off);
    logic [63:0] d;
    for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'((off + k) % 256);
    return d;
  endfunction

  task automatic drive(input int w, input logic [63:0] d, input logic [7:0] k,
                       input logic l, input logic v);
    if (w == 0) begin
      d0_data = d; d0_keep = k; d0_last = l; d0_valid = v;
    end else begin
      d1_data = d; d1_keep = k; d1_last = l; d1_valid = v;
    end
  endtask

  function automatic logic ready_of(input int w);
    return (w == 0) ? rdy0 : rdy1;
  endfunction

  // Present one beat and hold it until the handshake edge has passed.
  task automatic send_beat(input int w, input logic [63:0] d, input logic [7:0] k, input logic l);
    int waited;
    waited = 0;
    drive(w, d, k, l, 1'b1);
    while (ready_of(w) !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (waited >= 200) begin
      n_fail++;
      $display("FAIL handshake_timeout: dut%0d READY low for %0d cycles, required a handshake", w, waited);
    end
    @(negedge clk);
    drive(w, 64'h0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic expect0(input string tag, input logic [31:0] p, input logic [31:0] b,
                         input logic [15:0] e, input logic f, input logic [1:0] c);
    check({tag, ".pkt_count"},      64'(pkt0),  64'(p));
    check({tag, ".byte_count"},     64'(byt0),  64'(b));
    check({tag, ".err_count"},      64'(err0),  64'(e));
    check({tag, ".err_flag"},       64'(flag0), 64'(f));
    check({tag, ".first_err_code"}, 64'(code0), 64'(c));
  endtask

  task automatic expect1(input string tag, input logic [31:0] p, input logic [31:0] b,
                         input logic [15:0] e, input logic f, input logic [1:0] c);
    check({tag, ".pkt_count"},      64'(pkt1),  64'(p));
    check({tag, ".byte_count"},     64'(byt1),  64'(b));
    check({tag, ".err_count"},      64'(err1),  64'(e));
    check({tag, ".err_flag"},       64'(flag1), 64'(f));
    check({tag, ".first_err_code"}, 64'(code1), 64'(c));
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  int ready_pin [5] = '{1, 0, 0, 0, 1};   // READY after release for seed 0xACE1

  initial begin
    logic [63:0] d;
    logic [31:0] base_bytes;
    logic [31:0] base_pkts;
    int          n_hi;
    int          beat;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst.d0.ready", 64'(rdy0), 64'd0);
    check("rst.d1.ready", 64'(rdy1), 64'd0);
    expect0("rst.d0", 32'd0, 32'd0, 16'd0, 1'b0, 2'b00);
    expect1("rst.d1", 32'd0, 32'd0, 16'd0, 1'b0, 2'b00);

    // Release: READY follows the LFSR from the first cycle (zero seed -> 0xACE1).
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("rel.d1.ready[%0d]", i), 64'(rdy1), 64'(ready_pin[i]));
      check($sformatf("rel.d0.ready[%0d]", i), 64'(rdy0), 64'd1);
    end

    // Three-beat packet, bytes 0x00..0x17.
    send_beat(0, pat(0),  8'hFF, 1'b0);
    send_beat(0, pat(8),  8'hFF, 1'b0);
    send_beat(0, pat(16), 8'hFF, 1'b1);
    expect0("p3", 32'd1, 32'd24, 16'd0, 1'b0, 2'b00);

    // Single-beat packet with partial keep; upper lanes are garbage and ignored.
    send_beat(0, {32'hDEADBEEF, 32'h03020100}, 8'h0F, 1'b1);
    expect0("p1k0f", 32'd2, 32'd28, 16'd0, 1'b0, 2'b00);

    // Length error at MAX_BEATS=4, remaining beats drained unchecked.
    do_reset();
    expect0("rst2", 32'd0, 32'd0, 16'd0, 1'b0, 2'b00);
    send_beat(0, pat(0),  8'hFF, 1'b0);
    send_beat(0, pat(8),  8'hFF, 1'b0);
    send_beat(0, pat(16), 8'hFF, 1'b0);
    send_beat(0, pat(24), 8'hFF, 1'b0);
    expect0("len.b4", 32'd0, 32'd32, 16'd1, 1'b1, 2'b11);
    send_beat(0, 64'h0123456789ABCDEF, 8'hFF, 1'b0);
    send_beat(0, 64'hFEDCBA9876543210, 8'hFF, 1'b1);
    expect0("len.b6", 32'd1, 32'd48, 16'd1, 1'b1, 2'b11);
    // After draining, a new packet starts again at offset 0.
    send_beat(0, pat(0), 8'hFF, 1'b1);
    expect0("len.next", 32'd2, 32'd56, 16'd1, 1'b1, 2'b11);

    // Length outranks keep and data on the same beat.
    do_reset();
    send_beat(0, pat(0),  8'hFF, 1'b0);
    send_beat(0, pat(8),  8'hFF, 1'b0);
    send_beat(0, pat(16), 8'hFF, 1'b0);
    send_beat(0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h3F, 1'b0);
    send_beat(0, 64'h0, 8'h01, 1'b1);
    expect0("prio.len", 32'd1, 32'd31, 16'd1, 1'b1, 2'b11);

    // Keep outranks data.
    do_reset();
    send_beat(0, 64'hEEEE_EEEE_EEEE_EEEE, 8'h05, 1'b1);
    expect0("prio.keep", 32'd1, 32'd2, 16'd1, 1'b1, 2'b10);

    // Data error on beat 1 lane 2, then later errors leave the first code.
    do_reset();
    send_beat(0, pat(0), 8'hFF, 1'b0);
    d = pat(8);
    d[23:16] = 8'hAA;
    send_beat(0, d, 8'hFF, 1'b1);
    expect0("data", 32'd1, 32'd16, 16'd1, 1'b1, 2'b01);
    send_beat(0, pat(0), 8'h05, 1'b1);                 // non-contiguous LAST keep
    expect0("keep.last", 32'd2, 32'd18, 16'd2, 1'b1, 2'b01);
    send_beat(0, pat(0), 8'h7F, 1'b0);                 // partial keep on non-LAST
    send_beat(0, pat(8), 8'hFF, 1'b1);
    expect0("keep.mid", 32'd3, 32'd33, 16'd3, 1'b1, 2'b01);
    d = pat(0);
    d[47:40] = 8'h99;                                  // lane 5 disabled by keep
    send_beat(0, d, 8'h1F, 1'b1);
    expect0("keep.mask", 32'd4, 32'd38, 16'd3, 1'b1, 2'b01);
    send_beat(0, pat(0), 8'h00, 1'b1);                 // empty LAST keep
    expect0("keep.zero", 32'd5, 32'd38, 16'd4, 1'b1, 2'b01);

    // Reset in the middle of a packet under backpressure.
    expect1("mid.before", 32'd0, 32'd0, 16'd0, 1'b0, 2'b00);
    send_beat(1, pat(0), 8'hFF, 1'b0);
    send_beat(1, pat(8), 8'hFF, 1'b0);
    expect1("mid.open", 32'd0, 32'd16, 16'd0, 1'b0, 2'b00);
    do_reset();
    expect1("mid.rst", 32'd0, 32'd0, 16'd0, 1'b0, 2'b00);
    send_beat(1, pat(0), 8'hFF, 1'b0);
    send_beat(1, pat(8), 8'hFF, 1'b1);
    expect1("mid.fresh", 32'd1, 32'd16, 16'd0, 1'b0, 2'b00);

    // VALID held high for 1000 cycles; data advances on each handshake.
    base_bytes = byt1;
    base_pkts  = pkt1;
    n_hi = 0;
    beat = 0;
    for (int c = 0; c < 1000; c++) begin
      drive(1, pat((beat % 5) * 8), 8'hFF, (beat % 5) == 4, 1'b1);
      if (rdy1 === 1'b1) begin
        n_hi++;
        beat++;
      end
      @(negedge clk);
    end
    drive(1, 64'h0, 8'h00, 1'b0, 1'b0);
    check("bp.bytes", 64'(byt1 - base_bytes), 64'(n_hi * 8));
    check("bp.pkts",  64'(pkt1 - base_pkts),  64'(n_hi / 5));
    check("bp.errs",  64'(err1), 64'd0);
    check("bp.ratio_700_800", 64'(n_hi >= 700 && n_hi <= 800), 64'd1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_stream_checker.md
AXIS_STREAM_CHECKER -- requirements
Module: axis_stream_checker

Interface
REQ-001 Parameter SEED, default 16'hACE1, initial value of the backpressure LFSR; value 0 SHALL be replaced by 16'hACE1.
REQ-002 Parameter BP_ENABLE, default 1, selects pseudo-random backpressure (1) or permanent ready (0).
REQ-003 Parameter MAX_BEATS, default 256, maximum legal beats per packet.
REQ-004 Port clk, input, 1 bit: single clock; every register SHALL be clocked on its rising edge.
REQ-005 Port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port stream_in_DATA, input, 64 bits: payload from the DUT stream output.
REQ-007 Port stream_in_KEEP, input, 8 bits: byte enables; bit k qualifies DATA[8k+7:8k].
REQ-008 Port stream_in_LAST, input, 1 bit: final beat of a packet.
REQ-009 Port stream_in_VALID, input, 1 bit: beat valid.
REQ-010 Port stream_in_READY, output, 1 bit: checker accepts the beat.
REQ-011 Port pkt_count, output, 32 bits: completed packets.
REQ-012 Port byte_count, output, 32 bits: accepted bytes (keep popcount).
REQ-013 Port err_count, output, 16 bits: detected errors.
REQ-014 Port err_flag, output, 1 bit: sticky, any error since reset.
REQ-015 Port first_err_code, output, 2 bits: first error type (01 data, 10 keep, 11 length).

Function
REQ-016 A beat SHALL be accepted only in a cycle where VALID and READY are both 1; no other cycle changes any state except the LFSR.
REQ-017 READY SHALL be a registered output: READY = lfsr[0] OR lfsr[1] when BP_ENABLE=1 (nominal 75%), constant 1 after reset when BP_ENABLE=0.
REQ-018 LFSR: 16-bit Fibonacci, taps 16,14,13,11, SHALL advance every cycle regardless of handshake.
REQ-019 FSM states: IDLE (no packet open), IN_PKT (packet open), DRAIN (discard after length error).
REQ-020 IDLE: accepted beat with LAST=0 -> IN_PKT; accepted beat with LAST=1 -> single-beat packet, stay IDLE.
REQ-021 IN_PKT: accepted beat with LAST=1 -> IDLE; accepted beat making beat count equal MAX_BEATS with LAST=0 -> length error, DRAIN.
REQ-022 DRAIN: beats are accepted, counted in byte_count, not data/keep-checked; accepted LAST -> IDLE.
REQ-023 Expected data: lane k with KEEP[k]=1 SHALL equal (off + k) mod 256, where off is the packet's byte offset (0 at first beat, +8 per accepted beat); lanes with KEEP[k]=0 are ignored.
REQ-024 Keep rule: non-LAST beats SHALL have KEEP=8'hFF; LAST beat SHALL have nonzero, LSB-contiguous KEEP (8'h01, 03, ... FF).
REQ-025 At most one error SHALL be counted per beat; priority length > keep > data.
REQ-026 pkt_count SHALL increment on every accepted LAST beat (including from DRAIN); pkt_count and byte_count wrap modulo 2^32.
REQ-027 err_count SHALL saturate at 16'hFFFF; err_flag and first_err_code SHALL stay set once written.
REQ-028 All counters/flags SHALL update one cycle after the accepting edge (registered), with no combinational path from inputs to outputs.

Reset
REQ-029 While resetn=0 at a clock edge: FSM=IDLE, offsets/beat count=0, pkt_count=0, byte_count=0, err_count=0, err_flag=0, first_err_code=00, READY=0, LFSR=SEED.
REQ-030 Reset asserted mid-packet SHALL abandon the packet with no error recorded; the next accepted beat begins a new packet at off=0.
REQ-031 First cycle after reset release, READY SHALL reflect the LFSR (or 1 if BP_ENABLE=0).

Verification
REQ-032 BP_ENABLE=0, one 3-beat packet bytes 0x00..0x17, last KEEP=8'hFF -> pkt_count=1, byte_count=24, err_count=0, READY constantly 1.
REQ-033 Single beat, KEEP=8'h0F, DATA low bytes 03 02 01 00 -> pkt_count=1, byte_count=4, no error.
REQ-034 Beat 1 lane 2 = 0xAA instead of 0x0A -> err_count=1, err_flag=1, first_err_code=01; later keep error leaves code 01.
REQ-035 MAX_BEATS=4, 6-beat packet -> length error on beat 4, beats 5-6 drained, err_count=1, code=11, pkt_count=1, byte_count=48.
REQ-036 BP_ENABLE=1, VALID held 1 over 1000 cycles -> accepted beats equal READY-high cycles, ratio 0.70-0.80, no data held beyond handshake.
REQ-037 resetn pulled low after beat 2 of 4, then fresh packet sent -> all counters 0 before, new packet checked from off=0, err_count=0.
